// File: rtl/dual_port_ram_param.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_param
// Purpose  : True dual-port synchronous RAM with a single clock. Each port has
//            per-byte write enables. The read-during-write policy is
//            selectable. Same-address conflicts are resolved deterministically
//            and flagged. Memory clearing is done by a one-word-per-cycle
//            engine so the array carries no reset and can map to block RAM.
// Ports    : clk                      - clock, rising edge
//            reset                    - synchronous active-high, starts clear
//            clr_busy                 - clear engine running, ports ignored
//            en_x/we_x/be_x/addr_x/din_x - port x request (x = a, b)
//            dout_x/vld_x             - port x read data and valid strobe
//            collision                - same-address conflict (1-cycle pulse)
// Options  : DPRAM_OUTREG_EN - when defined, adds an output register stage on
//            dout/vld (read latency 2). collision keeps latency 1.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_ram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                clr_busy,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   din_a,
  output logic [DATA_W-1:0]   dout_a,
  output logic                vld_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   din_b,
  output logic [DATA_W-1:0]   dout_b,
  output logic                vld_b,
  output logic                collision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic                act_a, act_b;
  logic                wr_a, wr_b;
  logic                same_addr;
  logic [DATA_W-1:0]   old_a, old_b;
  logic [DATA_W-1:0]   merged_a, merged_b;
  logic [DATA_W-1:0]   rd_a, rd_b;

  // first output stage (the only stage unless DPRAM_OUTREG_EN is defined)
  logic [DATA_W-1:0]   dout_a_s, dout_b_s;
  logic                vld_a_s, vld_b_s;

  // Requests are swallowed entirely while the clear engine owns the array.
  assign act_a     = en_a & ~clr_busy;
  assign act_b     = en_b & ~clr_busy;
  assign wr_a      = act_a & we_a;
  assign wr_b      = act_b & we_b;
  assign same_addr = (addr_a == addr_b);

  // merged_x is the word that addr_x will hold after this edge: B lanes are
  // applied first, then A lanes override, so A wins on doubly-enabled lanes.
  always_comb begin
    old_a    = mem[addr_a];
    old_b    = mem[addr_b];
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_b && be_b[i] && same_addr) merged_a[8*i +: 8] = din_b[8*i +: 8];
      if (wr_a && be_a[i])              merged_a[8*i +: 8] = din_a[8*i +: 8];
      if (wr_b && be_b[i])              merged_b[8*i +: 8] = din_b[8*i +: 8];
      if (wr_a && be_a[i] && same_addr) merged_b[8*i +: 8] = din_a[8*i +: 8];
    end
    rd_a = (RDW_MODE == 1) ? merged_a : old_a;
    rd_b = (RDW_MODE == 1) ? merged_b : old_b;
  end

  // Clear sequencer: one word per cycle, restarts from 0 on any reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
      clr_busy <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == {ADDR_W{1'b1}}) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage array, deliberately without reset. Port A's assignments come
  // after port B's so that A's lane data lands on a same-address conflict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
          if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
        end
      end
    end
  end

  // Read data / valid / collision. dout holds when the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_a_s  <= '0;
      dout_b_s  <= '0;
      vld_a_s   <= 1'b0;
      vld_b_s   <= 1'b0;
      collision <= 1'b0;
    end else begin
      vld_a_s   <= act_a;
      vld_b_s   <= act_b;
      collision <= act_a & act_b & same_addr & (we_a | we_b);
      if (act_a) dout_a_s <= rd_a;
      if (act_b) dout_b_s <= rd_b;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [DATA_W-1:0] dout_a_p, dout_b_p;
  logic              vld_a_p, vld_b_p;

  // Extra output stage; zeroed while clearing so no stale word leaks out.
  always_ff @(posedge clk) begin
    if (reset || clr_busy) begin
      dout_a_p <= '0;
      dout_b_p <= '0;
      vld_a_p  <= 1'b0;
      vld_b_p  <= 1'b0;
    end else begin
      dout_a_p <= dout_a_s;
      dout_b_p <= dout_b_s;
      vld_a_p  <= vld_a_s;
      vld_b_p  <= vld_b_s;
    end
  end

  assign dout_a = dout_a_p;
  assign dout_b = dout_b_p;
  assign vld_a  = vld_a_p;
  assign vld_b  = vld_b_p;
`else
  assign dout_a = dout_a_s;
  assign dout_b = dout_b_s;
  assign vld_a  = vld_a_s;
  assign vld_b  = vld_b_s;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_ram_param
// Purpose  : Self-checking bench for dual_port_ram_param (DATA_W=16,
//            ADDR_W=4). Two instances, read-first and write-first, share one
//            stimulus stream and are compared every cycle against a
//            word-level model of the memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_param;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          en_a, we_a, en_b, we_b;
  logic [1:0]    be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;

  logic          busy0, busy1, vld_a0, vld_b0, vld_a1, vld_b1, col0, col1;
  logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .clr_busy(busy0),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a0), .vld_a(vld_a0),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b0), .vld_b(vld_b0), .collision(col0)
  );

  dual_port_ram_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .clr_busy(busy1),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a1), .vld_a(vld_a1),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b1), .vld_b(vld_b1), .collision(col1)
  );

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_on   = 1'b0;
  bit            m_busy = 1'b0;
  int            m_ptr  = 0;
  // s_* : result of this edge's access; e_* : what the outputs must show.
  // index 0 = read-first instance, 1 = write-first instance
  logic [DW-1:0] s_da [2];
  logic [DW-1:0] s_db [2];
  logic [DW-1:0] e_da [2];
  logic [DW-1:0] e_db [2];
  bit            s_va, s_vb, e_va, e_vb, e_col;

  always @(posedge clk) begin
    bit            was_busy;
    logic [DW-1:0] old_a, old_b, w;
    was_busy = m_busy;
`ifdef DPRAM_OUTREG_EN
    if (reset || was_busy) begin
      e_da[0] = '0; e_da[1] = '0; e_db[0] = '0; e_db[1] = '0;
      e_va = 1'b0; e_vb = 1'b0;
    end else begin
      e_da = s_da; e_db = s_db; e_va = s_va; e_vb = s_vb;
    end
`endif
    if (reset) begin
      m_on = 1'b1; m_busy = 1'b1; m_ptr = 0;
      s_da[0] = '0; s_da[1] = '0; s_db[0] = '0; s_db[1] = '0;
      s_va = 1'b0; s_vb = 1'b0; e_col = 1'b0;
    end else if (m_busy) begin
      m_mem[m_ptr] = '0;
      m_ptr++;
      if (m_ptr == DEPTH) m_busy = 1'b0;
      s_va = 1'b0; s_vb = 1'b0; e_col = 1'b0;
    end else begin
      old_a = m_mem[addr_a];
      old_b = m_mem[addr_b];
      if (en_b && we_b) begin
        w = m_mem[addr_b];
        if (be_b[0]) w[7:0]  = din_b[7:0];
        if (be_b[1]) w[15:8] = din_b[15:8];
        m_mem[addr_b] = w;
      end
      if (en_a && we_a) begin
        w = m_mem[addr_a];
        if (be_a[0]) w[7:0]  = din_a[7:0];
        if (be_a[1]) w[15:8] = din_a[15:8];
        m_mem[addr_a] = w;
      end
      e_col = en_a && en_b && (addr_a == addr_b) && (we_a || we_b);
      s_va = en_a;
      s_vb = en_b;
      if (en_a) begin s_da[0] = old_a; s_da[1] = m_mem[addr_a]; end
      if (en_b) begin s_db[0] = old_b; s_db[1] = m_mem[addr_b]; end
    end
`ifndef DPRAM_OUTREG_EN
    e_da = s_da; e_db = s_db; e_va = s_va; e_vb = s_vb;
`endif
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (m_on) begin
      check("clr_busy0", 32'(busy0), 32'(m_busy));
      check("clr_busy1", 32'(busy1), 32'(m_busy));
      check("vld_a0", 32'(vld_a0), 32'(e_va));
      check("vld_b0", 32'(vld_b0), 32'(e_vb));
      check("vld_a1", 32'(vld_a1), 32'(e_va));
      check("vld_b1", 32'(vld_b1), 32'(e_vb));
      check("collision0", 32'(col0), 32'(e_col));
      check("collision1", 32'(col1), 32'(e_col));
      check("dout_a0", 32'(dout_a0), 32'(e_da[0]));
      check("dout_b0", 32'(dout_b0), 32'(e_db[0]));
      check("dout_a1", 32'(dout_a1), 32'(e_da[1]));
      check("dout_b1", 32'(dout_b1), 32'(e_db[1]));
    end
  endtask

  // one cycle: compare at the falling edge, caller then drives new inputs
  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; be_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; be_b = 0; addr_b = 0; din_b = 0;
  endtask

  task automatic drv_a(input logic we, input logic [1:0] be, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    en_a = 1; we_a = we; be_a = be; addr_a = ad; din_a = d;
  endtask

  task automatic drv_b(input logic we, input logic [1:0] be, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    en_b = 1; we_b = we; be_b = be; addr_b = ad; din_b = d;
  endtask

  task automatic wait_lat();
    for (int i = 0; i < LAT; i++) begin
      tick();
      idle();
    end
  endtask

  // counts falling edges with clr_busy high, starting from the current one
  task automatic count_busy(input string nm);
    int cnt;
    cnt = 0;
    while (busy0 && cnt < 100) begin
      cnt++;
      tick();
      idle();
    end
    check(nm, 32'(cnt), 32'd16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();

    // 1: one-cycle reset pulse, 16 busy cycles, memory reads back zero
    tick();
    reset = 1'b0;
    count_busy("busy_len_t1");
    for (int a = 0; a < DEPTH; a++) begin
      drv_a(1'b0, 2'b00, AW'(a), '0);
      wait_lat();
      check("clear_rd", 32'(dout_a0), 32'h0000);
    end

    // 2: A writes, B reads one cycle later
    tick(); drv_a(1'b1, 2'b11, 4'd3, 16'hBEEF);
    tick(); idle(); drv_b(1'b0, 2'b00, 4'd3, '0);
    wait_lat();
    check("t2_dout_b", 32'(dout_b0), 32'hBEEF);
    check("t2_vld_b", 32'(vld_b0), 32'd1);
    tick();
    check("t2_vld_b_drop", 32'(vld_b0), 32'd0);

    // 3: partial byte write merges with old contents
    drv_a(1'b1, 2'b11, 4'd5, 16'h1234);
    tick(); drv_a(1'b1, 2'b10, 4'd5, 16'hAB00);
    tick(); drv_a(1'b0, 2'b00, 4'd5, '0);
    wait_lat();
    check("t3_merge", 32'(dout_a0), 32'hAB34);

    // 4: both ports write the same address on the same edge
    tick(); drv_a(1'b1, 2'b01, 4'd7, 16'h1111); drv_b(1'b1, 2'b11, 4'd7, 16'h2222);
    tick(); idle();
    check("t4_collision", 32'(col0), 32'd1);
    check("t4_model", 32'(m_mem[7]), 32'h2211);
    tick();
    check("t4_collision_drop", 32'(col0), 32'd0);
    drv_b(1'b0, 2'b00, 4'd7, '0);
    wait_lat();
    check("t4_rd", 32'(dout_b0), 32'h2211);

    // 5: write on A while B reads the same address
    tick(); drv_a(1'b1, 2'b11, 4'd2, 16'h00AA);
    tick(); drv_a(1'b1, 2'b11, 4'd2, 16'h5555); drv_b(1'b0, 2'b00, 4'd2, '0);
    tick(); idle();
    check("t5_collision0", 32'(col0), 32'd1);
    check("t5_collision1", 32'(col1), 32'd1);
    if (LAT > 1) begin
      tick();
      idle();
    end
    check("t5_read_first", 32'(dout_b0), 32'h00AA);
    check("t5_write_first", 32'(dout_b1), 32'h5555);

    // 6: reset re-asserted mid-clear; writes during busy are dropped
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("t6_model_ptr", 32'(m_ptr), 32'd8);
    reset = 1'b1;
    tick(); reset = 1'b0; drv_a(1'b1, 2'b11, 4'd1, 16'hFFFF);
    count_busy("busy_len_t6");
    drv_a(1'b0, 2'b00, 4'd1, '0);
    wait_lat();
    check("t6_rd", 32'(dout_a0), 32'h0000);

    // randomized traffic, narrow address range to provoke conflicts
    for (int n = 0; n < 600; n++) begin
      tick();
      reset  = ($urandom_range(0, 149) == 0);
      en_a   = $urandom_range(0, 3) != 0;
      we_a   = $urandom_range(0, 1) != 0;
      be_a   = 2'($urandom_range(0, 3));
      addr_a = AW'($urandom_range(0, 3));
      din_a  = DW'($urandom);
      en_b   = $urandom_range(0, 3) != 0;
      we_b   = $urandom_range(0, 1) != 0;
      be_b   = 2'($urandom_range(0, 3));
      addr_b = AW'($urandom_range(0, 3));
      din_b  = DW'($urandom);
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 20; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
